// File: rtl/mult_res_reader_pkg.sv
// Shared multiplier package: reader FSM state encoding and beat-counter sizing.
package mult_res_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } rdState_e;

  function automatic int beatCntWidth(input int width);
    return $clog2(2 * width);
  endfunction

  localparam int BEAT_CNT_W = beatCntWidth(6);

endpackage

// File: rtl/mult_res_reader_fifo.sv
// skid_fifo2: two-entry FIFO whose head is a plain register, so the
// downstream outputs never pass through combinational muxing.
module skid_fifo2 #(
  parameter int DW = 66
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] pushData_i,
  input  logic          pop_i,
  output logic [DW-1:0] headData_o,
  output logic          headValid_o,
  output logic [1:0]    count_o
);

  logic [DW-1:0] slot0_q;
  logic [DW-1:0] slot1_q;
  logic [1:0]    count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          if (count_q == 2'd0) slot0_q <= pushData_i;
          else                 slot1_q <= pushData_i;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          slot0_q <= slot1_q;
          count_q <= count_q - 2'd1;
        end
        // Pass-through with one entry keeps the new word behind nothing.
        2'b11: begin
          if (count_q == 2'd1) begin
            slot0_q <= pushData_i;
          end else begin
            slot0_q <= slot1_q;
            slot1_q <= pushData_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign headData_o  = slot0_q;
  assign headValid_o = (count_q != 2'd0);
  assign count_o     = count_q;

endmodule

// File: rtl/mult_res_reader.sv
// Streams both multiplier result operands out through a 2-entry FIFO.
// Define RES_READER_INTERLEAVE_EN to interleave mult_0/mult_1 digits.
module mult_res_reader
  import mult_res_reader_pkg::*;
#(
  parameter int RADIX     = 64,
  parameter int WIDTH     = 6,
  parameter int WIDTH_LOG = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 mult_0_mem_res_rd_en,
  output logic [WIDTH_LOG-1:0] mult_0_mem_res_rd_addr,
  input  logic [RADIX-1:0]     mult_0_mem_res_dout,
  output logic                 mult_1_mem_res_rd_en,
  output logic [WIDTH_LOG-1:0] mult_1_mem_res_rd_addr,
  input  logic [RADIX-1:0]     mult_1_mem_res_dout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [RADIX-1:0]     out_data,
  output logic                 out_sel,
  output logic                 out_last
);

  localparam int BCW = beatCntWidth(WIDTH);
  localparam int FW  = RADIX + 2;
  localparam logic [BCW-1:0]       LAST_READ = BCW'(2 * WIDTH - 1);
  localparam logic [WIDTH_LOG-1:0] LAST_PTR  = WIDTH_LOG'(WIDTH - 1);

  rdState_e             state_q;
  logic [BCW-1:0]       readCnt_q;
  logic [WIDTH_LOG-1:0] ptr_q;
  logic                 memSel_q;
  logic                 pend_q;
  logic                 pendSel_q;
  logic                 pendLast_q;
  logic                 busy_q;
  logic                 done_q;

  logic [FW-1:0]        headData;
  logic                 headValid;
  logic [1:0]           fifoCount;
  logic                 pop;
  logic                 issue;
  logic                 lastIssue;
  logic [2:0]           fillAfter;
  logic [RADIX-1:0]     retData;

  // A new read lands two edges from now; admit it only if a slot is certain.
  assign pop       = headValid & out_ready;
  assign fillAfter = {1'b0, fifoCount} + {2'b00, pend_q} - {2'b00, pop};
  assign issue     = (state_q == READ) && (fillAfter <= 3'd1);
  assign lastIssue = (readCnt_q == LAST_READ);
  assign retData   = pendSel_q ? mult_1_mem_res_dout : mult_0_mem_res_dout;

  skid_fifo2 #(.DW(FW)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (pend_q),
    .pushData_i  ({pendLast_q, pendSel_q, retData}),
    .pop_i       (pop),
    .headData_o  (headData),
    .headValid_o (headValid),
    .count_o     (fifoCount)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      readCnt_q  <= '0;
      ptr_q      <= '0;
      memSel_q   <= 1'b0;
      pend_q     <= 1'b0;
      pendSel_q  <= 1'b0;
      pendLast_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      pend_q     <= issue;
      pendSel_q  <= memSel_q;
      pendLast_q <= lastIssue;
      done_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= READ;
            busy_q    <= 1'b1;
            readCnt_q <= '0;
            ptr_q     <= '0;
            memSel_q  <= 1'b0;
          end else if (done_q) begin
            busy_q <= 1'b0;
          end
        end
        READ: begin
          if (issue) begin
            readCnt_q <= readCnt_q + BCW'(1);
`ifdef RES_READER_INTERLEAVE_EN
            memSel_q <= ~memSel_q;
            if (memSel_q) ptr_q <= (ptr_q == LAST_PTR) ? '0 : ptr_q + WIDTH_LOG'(1);
`else
            if (ptr_q == LAST_PTR) begin
              ptr_q    <= '0;
              memSel_q <= ~memSel_q;
            end else begin
              ptr_q <= ptr_q + WIDTH_LOG'(1);
            end
`endif
            if (lastIssue) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && headData[FW-1]) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy                   = busy_q;
  assign done                   = done_q;
  assign mult_0_mem_res_rd_en   = issue & ~memSel_q;
  assign mult_1_mem_res_rd_en   = issue & memSel_q;
  assign mult_0_mem_res_rd_addr = ptr_q;
  assign mult_1_mem_res_rd_addr = ptr_q;
  assign out_valid              = headValid;
  assign out_last               = headData[FW-1];
  assign out_sel                = headData[FW-2];
  assign out_data               = headData[RADIX-1:0];

endmodule
